// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : uart_pkg                                                   |
// | Description : Shared UART definitions: parity encodings, the receive     |
// |               FSM state type and a majority-of-three helper. Used by the |
// |               receive deframer and the transmit-side frame generator.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uart_pkg;

   // Encodings of the parity_type control input.
   localparam logic [1:0] PARITY_NONE     = 2'b00;
   localparam logic [1:0] PARITY_ODD      = 2'b01;
   localparam logic [1:0] PARITY_EVEN     = 2'b10;
   localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

   // Receive FSM states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } rx_state_e;

   // Majority of three samples.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_sampler                                            |
// | Description : Line conditioning and bit timing for the UART receiver.    |
// |               2-flop synchronizer (reset to 1), oversample tick counter  |
// |               and the per-bit sample strobe. With the macro              |
// |               UART_RX_MAJORITY_VOTE_EN defined, each bit value is the    |
// |               majority of the samples at mid-1, mid and mid+1 and the    |
// |               strobe fires at mid+1.                                     |
// | Ports       : clk, rst        - clock, synchronous active-high reset     |
// |               rx_in           - raw asynchronous serial line             |
// |               sample_tick     - oversample strobe                        |
// |               clear           - hold tick counter at 0 (FSM idle)        |
// |               half_mode       - start bit: strobe half a bit after entry |
// |               rx_sync         - synchronized line value                  |
// |               sampled_bit     - bit value, valid with sample_strobe      |
// |               sample_strobe   - one-clk strobe at the bit decision point |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int CNT_W      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic rx_in,
   input  logic sample_tick,
   input  logic clear,
   input  logic half_mode,
   output logic rx_sync,
   output logic sampled_bit,
   output logic sample_strobe
);

   // Decision points. The counter restarts at 0 after each decision, so a
   // full-bit target of OVERSAMPLE-1 keeps later decisions exactly one bit
   // period after the start-bit decision.
`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam logic [CNT_W-1:0] c_half_tgt = CNT_W'(OVERSAMPLE / 2);
`else
   localparam logic [CNT_W-1:0] c_half_tgt = CNT_W'(OVERSAMPLE / 2 - 1);
`endif
   localparam logic [CNT_W-1:0] c_full_tgt = CNT_W'(OVERSAMPLE - 1);

   logic [1:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             w_hit;

   assign rx_sync = sync_q[1];
   assign w_hit   = sample_tick && !clear &&
                    (cnt_q == (half_mode ? c_half_tgt : c_full_tgt));
   assign sample_strobe = w_hit;

   always_comb begin
      sync_d = {sync_q[0], rx_in};
      cnt_d  = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (sample_tick)
         cnt_d = w_hit ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
      end
   end

`ifdef UART_RX_MAJORITY_VOTE_EN
   // Line values at the two previous ticks; combined with the current one
   // at the decision tick to give samples at mid-1, mid and mid+1.
   logic [1:0] hist_q, hist_d;

   always_comb begin
      hist_d = hist_q;
      if (sample_tick)
         hist_d = {hist_q[0], rx_sync};
   end

   always_ff @(posedge clk) begin
      if (rst)
         hist_q <= 2'b11;
      else
         hist_q <= hist_d;
   end

   assign sampled_bit = maj3(hist_q[1], hist_q[0], rx_sync);
`else
   assign sampled_bit = rx_sync;
`endif

endmodule : uart_rx_sampler
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_deframer                                           |
// | Description : UART receive deframer. Validates the start bit, shifts in  |
// |               7/8 data bits MSB first, checks optional parity and 1/2    |
// |               stop bits, and presents the byte with error flags and a    |
// |               one-clk data_valid pulse. Optional macro:                  |
// |               UART_RX_MAJORITY_VOTE_EN (3-sample majority per bit).      |
// | Ports       : clk, rst         - clock, synchronous active-high reset    |
// |               rx_in            - asynchronous serial line, idles high    |
// |               sample_tick      - OVERSAMPLE x baud strobe                |
// |               parity_type[1:0] - 00/11 none, 01 odd, 10 even             |
// |               stop_bits        - 0 one, 1 two stop bits                  |
// |               data_length      - 0 seven, 1 eight data bits              |
// |               data_out[7:0]    - received byte (held)                    |
// |               data_valid       - one-clk frame-complete pulse            |
// |               parity_error     - parity mismatch of last frame (held)    |
// |               frame_error      - stop bit low in last frame (held)       |
// |               busy             - validated start until completion        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic       sample_tick,
   input  logic [1:0] parity_type,
   input  logic       stop_bits,
   input  logic       data_length,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       parity_error,
   output logic       frame_error,
   output logic       busy
);

   rx_state_e  state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [1:0] ptype_q, ptype_d;
   logic       stop2_q, stop2_d;
   logic       len8_q, len8_d;
   logic       par_err_q, par_err_d;   // frame-local parity result
   logic       fe_q, fe_d;             // frame-local stop-bit error
   logic [7:0] data_out_q, data_out_d;
   logic       data_valid_q, data_valid_d;
   logic       parity_error_q, parity_error_d;
   logic       frame_error_q, frame_error_d;
   logic       busy_q, busy_d;

   logic w_rx_sync;
   logic w_bit;
   logic w_strobe;

   uart_rx_sampler #(
      .OVERSAMPLE (OVERSAMPLE),
      .CNT_W      (CNT_W)
   ) u_sampler (
      .clk           (clk),
      .rst           (rst),
      .rx_in         (rx_in),
      .sample_tick   (sample_tick),
      .clear         (state_q == ST_IDLE),
      .half_mode     (state_q == ST_START),
      .rx_sync       (w_rx_sync),
      .sampled_bit   (w_bit),
      .sample_strobe (w_strobe)
   );

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      ptype_d        = ptype_q;
      stop2_d        = stop2_q;
      len8_d         = len8_q;
      par_err_d      = par_err_q;
      fe_d           = fe_q;
      data_out_d     = data_out_q;
      data_valid_d   = 1'b0;
      parity_error_d = parity_error_q;
      frame_error_d  = frame_error_q;
      busy_d         = busy_q;

      case (state_q)
         ST_IDLE: begin
            // Level-sensitive: a line still low after a completed frame
            // re-enters START (repeated break frames).
            if (sample_tick && !w_rx_sync) begin
               state_d   = ST_START;
               ptype_d   = parity_type;
               stop2_d   = stop_bits;
               len8_d    = data_length;
               shift_d   = '0;
               bit_cnt_d = '0;
               par_err_d = 1'b0;
               fe_d      = 1'b0;
            end
         end
         ST_START: begin
            if (w_strobe) begin
               if (w_bit) begin
                  state_d = ST_IDLE;    // false start
               end else begin
                  state_d = ST_DATA;
                  busy_d  = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (w_strobe) begin
               // Shifting left leaves the first bit in bit 7 (8-bit) or
               // bit 6 (7-bit); bit 7 stays 0 in 7-bit mode.
               shift_d = {shift_q[6:0], w_bit};
               if (bit_cnt_q == (len8_q ? 3'd7 : 3'd6)) begin
                  if (ptype_q == PARITY_ODD || ptype_q == PARITY_EVEN)
                     state_d = ST_PARITY;
                  else
                     state_d = ST_STOP1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (w_strobe) begin
               par_err_d = (^shift_q) ^ w_bit ^ (ptype_q == PARITY_ODD);
               state_d   = ST_STOP1;
            end
         end
         ST_STOP1, ST_STOP2: begin
            if (w_strobe) begin
               if (state_q == ST_STOP1 && stop2_q) begin
                  fe_d    = fe_q | ~w_bit;
                  state_d = ST_STOP2;
               end else begin
                  data_out_d     = shift_q;
                  parity_error_d = par_err_q;
                  frame_error_d  = fe_q | ~w_bit;
                  data_valid_d   = 1'b1;
                  busy_d         = 1'b0;
                  state_d        = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         ptype_q        <= PARITY_NONE;
         stop2_q        <= 1'b0;
         len8_q         <= 1'b0;
         par_err_q      <= 1'b0;
         fe_q           <= 1'b0;
         data_out_q     <= '0;
         data_valid_q   <= 1'b0;
         parity_error_q <= 1'b0;
         frame_error_q  <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         ptype_q        <= ptype_d;
         stop2_q        <= stop2_d;
         len8_q         <= len8_d;
         par_err_q      <= par_err_d;
         fe_q           <= fe_d;
         data_out_q     <= data_out_d;
         data_valid_q   <= data_valid_d;
         parity_error_q <= parity_error_d;
         frame_error_q  <= frame_error_d;
         busy_q         <= busy_d;
      end
   end

   assign data_out     = data_out_q;
   assign data_valid   = data_valid_q;
   assign parity_error = parity_error_q;
   assign frame_error  = frame_error_q;
   assign busy         = busy_q;

endmodule : uart_rx_deframer
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rx_deframer                                        |
// | Description : Directed self-checking bench for uart_rx_deframer.         |
// |               Ticks every 4 clks, OVERSAMPLE 16 -> 64 clks per bit.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_rx_deframer;

   localparam int OVERSAMPLE = 16;
   localparam int BIT_CLKS   = OVERSAMPLE * 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic       sample_tick = 1'b0;
   logic [1:0] parity_type = 2'b00;
   logic       stop_bits = 1'b0;
   logic       data_length = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       parity_error;
   logic       frame_error;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;
   int valid_cnt = 0;
   logic busy_at_valid = 1'b1;
   logic busy_seen = 1'b0;

   uart_rx_deframer #(
      .OVERSAMPLE (OVERSAMPLE),
      .CNT_W      (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_in        (rx_in),
      .sample_tick  (sample_tick),
      .parity_type  (parity_type),
      .stop_bits    (stop_bits),
      .data_length  (data_length),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .parity_error (parity_error),
      .frame_error  (frame_error),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // One-clk tick every 4 clks, driven away from the active edge.
   initial begin
      forever begin
         repeat (3) @(negedge clk) sample_tick = 1'b0;
         @(negedge clk) sample_tick = 1'b1;
      end
   end

   // Monitor on the falling edge: count valid cycles and busy activity.
   always @(negedge clk) begin
      if (data_valid) begin
         valid_cnt     <= valid_cnt + 1;
         busy_at_valid <= busy;
      end
      if (busy)
         busy_seen <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx_in = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en,
                             input logic par_bit, input int nstop, input logic stop_val);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++)
         send_bit(data[nbits-1-i]);
      if (par_en)
         send_bit(par_bit);
      for (int i = 0; i < nstop; i++)
         send_bit(stop_val);
      send_bit(1'b1);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] exp_data, input logic exp_pe,
                              input logic exp_fe, input int exp_vcnt);
      check({tag, ".valid_cnt"}, valid_cnt, exp_vcnt);
      check({tag, ".data"}, {24'd0, data_out}, {24'd0, exp_data});
      check({tag, ".parity_error"}, {31'd0, parity_error}, {31'd0, exp_pe});
      check({tag, ".frame_error"}, {31'd0, frame_error}, {31'd0, exp_fe});
   endtask

   initial begin
      repeat (4) @(negedge clk);
      check("reset.data", {24'd0, data_out}, 32'h0);
      check("reset.valid", {31'd0, data_valid}, 32'h0);
      check("reset.pe", {31'd0, parity_error}, 32'h0);
      check("reset.fe", {31'd0, frame_error}, 32'h0);
      check("reset.busy", {31'd0, busy}, 32'h0);
      rst = 1'b0;
      repeat (2 * BIT_CLKS) @(negedge clk);

      // 8N1 0xA5
      parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
      busy_seen = 1'b0;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
      check_frame("8N1_A5", 8'hA5, 1'b0, 1'b0, 1);
      check("8N1_A5.busy_seen", {31'd0, busy_seen}, 32'h1);
      check("8N1_A5.busy_at_valid", {31'd0, busy_at_valid}, 32'h0);
      check("8N1_A5.busy_after", {31'd0, busy}, 32'h0);

      // 8E2 0x3C (four ones): parity 1 is wrong, parity 0 is right
      parity_type = 2'b10; stop_bits = 1'b1; data_length = 1'b1;
      send_frame(8'h3C, 8, 1'b1, 1'b1, 2, 1'b1);
      check_frame("8E2_bad", 8'h3C, 1'b1, 1'b0, 2);
      send_frame(8'h3C, 8, 1'b1, 1'b0, 2, 1'b1);
      check_frame("8E2_good", 8'h3C, 1'b0, 1'b0, 3);

      // 7O1 7'h41 (two ones) with parity 1 -> odd total, no error
      parity_type = 2'b01; stop_bits = 1'b0; data_length = 1'b0;
      send_frame(8'h41, 7, 1'b1, 1'b1, 1, 1'b1);
      check_frame("7O1_41", 8'h41, 1'b0, 1'b0, 4);
      check("7O1_41.bit7", {31'd0, data_out[7]}, 32'h0);

      // 7O1 7'h7F (seven ones) with parity 1 -> even total, error
      send_frame(8'h7F, 7, 1'b1, 1'b1, 1, 1'b1);
      check_frame("7O1_7F_bad", 8'h7F, 1'b1, 1'b0, 5);

      // 8N1 0x00 with low stop bit, then a good 0xFF
      parity_type = 2'b11; stop_bits = 1'b0; data_length = 1'b1;
      send_frame(8'h00, 8, 1'b0, 1'b0, 1, 1'b0);
      send_bit(1'b1);
      check_frame("8N1_brk", 8'h00, 1'b0, 1'b1, 6);
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1, 1'b1);
      check_frame("8N1_FF", 8'hFF, 1'b0, 1'b0, 7);

      // Short low glitch (OVERSAMPLE/4 ticks) on the idle line
      busy_seen = 1'b0;
      rx_in = 1'b0;
      repeat (OVERSAMPLE) @(negedge clk);
      rx_in = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      check("glitch.valid_cnt", valid_cnt, 7);
      check("glitch.busy_seen", {31'd0, busy_seen}, 32'h0);
      check("glitch.data_held", {24'd0, data_out}, 32'hFF);

      // Reset in DATA after 4 bits of 0x5A
      parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
      send_bit(1'b0);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      check("rstmid.busy_before", {31'd0, busy}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid.data", {24'd0, data_out}, 32'h0);
      check("rstmid.busy", {31'd0, busy}, 32'h0);
      check("rstmid.valid", {31'd0, data_valid}, 32'h0);
      check("rstmid.fe_pe", {30'd0, frame_error, parity_error}, 32'h0);
      rst = 1'b0;
      rx_in = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      check("rstmid.no_valid", valid_cnt, 7);
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
      check_frame("after_rst_5A", 8'h5A, 1'b0, 1'b0, 8);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Absolute time guard.
   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule : tb_uart_rx_deframer
`default_nettype wire

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Receive-side counterpart of the UART frame generator. Oversamples the serial line and detects and validates the start bit. Shifts in 7 or 8 data bits, then checks the optional parity bit and 1 or 2 stop bits. Presents the recovered byte with error flags as a one-cycle valid pulse to the host side of the UART.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; must be ≥ 8 and even.
- CNT_W, 4, width of the tick counter; must satisfy 2^CNT_W ≥ OVERSAMPLE.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- rx_in  in  1  asynchronous serial line; idles high.
- sample_tick  in  1  one-clk strobe at OVERSAMPLE × baud rate.
- parity_type  in  2  00 none, 01 odd, 10 even, 11 none.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- data_length  in  1  0 = 7 data bits, 1 = 8 data bits.
- data_out  out  8  received byte; bit 7 forced to 0 in 7-bit mode.
- data_valid  out  1  one-clk pulse when a frame completes.
- parity_error  out  1  parity mismatch for the last frame.
- frame_error  out  1  a stop bit was sampled low in the last frame.
- busy  out  1  high from validated start until frame completion.

Behaviour:
- Input conditioning:
  - rx_in passes through a 2-flop synchronizer, reset to 1; all logic uses the synchronized value.
  - Edge detection is on the synchronized value.
- Reset: all outputs are 0, state is IDLE, tick counter is 0, shift register is 0, synchronizer flops are 1. A reset mid-frame aborts the frame with no data_valid.
- All FSM activity advances only on clk cycles where sample_tick = 1, except the data_valid pulse and the return to IDLE.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - On synchronized line = 0, clear the tick counter and go to START.
  - parity_type, stop_bits and data_length are captured into internal registers at this transition and used for the whole frame.
- START:
  - At tick count OVERSAMPLE/2−1 (mid start bit), sample the line.
  - If the sample is 1, it is a false start: return to IDLE with no flags.
  - If the sample is 0, set busy, clear the counter and go to DATA.
- DATA:
  - Sample every OVERSAMPLE ticks (mid-bit).
  - Bits arrive MSB first: the first data bit lands in data bit 7 (8-bit mode) or bit 6 (7-bit mode).
  - After 8 or 7 samples, go to PARITY if parity_type is 01 or 10, otherwise to STOP1.
- PARITY:
  - Sample the parity bit at mid-bit.
  - err = XOR(data bits, parity bit) XOR (parity_type == 01). Odd parity requires the total XOR to be 1; even parity requires it to be 0.
- STOP1:
  - Sample at mid-bit; a 0 sets the internal frame-error flag.
  - If two stop bits are configured, go to STOP2; otherwise complete the frame.
- STOP2: same check as STOP1, then complete the frame.
- Completion, in the same clk as the final stop sample:
  - Register data_out, parity_error and frame_error.
  - Pulse data_valid for exactly 1 clk and drop busy.
  - Go to IDLE.
- Output hold: data_out and both error flags hold until the next completion or reset.
- Back-to-back frames: the state is IDLE on the clk after completion, so a start edge arriving half a bit after the stop-bit sample is caught.
- No-parity modes: parity_error is always 0.
- Unsampled bits: data_out bits beyond data_length are 0.
- Break: a line held low throughout yields data 0x00 with frame_error = 1, then IDLE. Re-entry into START requires the line to be low again; a held-low line causes repeated frames each flagged frame_error.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit value (start, data, parity, stop) is the majority of three samples at tick counts mid−1, mid, mid+1.
  - The decision is made at mid+1, so completion occurs 1 tick later than without the macro.
- Undefined: single sample at mid-bit, as described in Behaviour.

Decomposition:
- Package uart_pkg:
  - Parity encodings: PARITY_NONE = 2'b00, PARITY_ODD = 2'b01, PARITY_EVEN = 2'b10, PARITY_NONE_ALT = 2'b11.
  - State enum for the receive FSM.
  - Shared with the transmit-side frame generator.
- One natural sub-module, uart_rx_sampler:
  - Contains the synchronizer, the tick counter and the mid-bit / majority-vote sample strobe.
  - Outputs sampled_bit and sample_strobe to the FSM.

Test Plan:
- 8N1, serial 0xA5 (MSB first), stop = 1: data_valid pulses once, data_out = 0xA5, parity_error = 0, frame_error = 0, busy falls with the valid pulse.
- 8E2, serial 0x3C with parity bit 1 (wrong): data_out = 0x3C, parity_error = 1, frame_error = 0; the next frame 0x3C with parity 0 clears parity_error.
- 7O1, serial 7'h41 with parity 1: data_out = 0x41, parity_error = 0; bit 7 = 0.
- 8N1, 0x00 with stop bit 0: frame_error = 1, data_out = 0x00; a following valid 0xFF frame clears frame_error.
- Low glitch of OVERSAMPLE/4 ticks on idle line: no data_valid, busy never asserts, state returns to IDLE.
- rst asserted in DATA after 4 bits: next clk all outputs are 0; the following full 8N1 0x5A frame is received correctly.
